// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU constants, the serial-adder state type and a nibble-count helper.
package alu_pkg;

    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned WORD_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nsa_state_t;

    // Number of 4-bit slices needed to cover a word of the given width.
    function automatic int unsigned nibble_count(input int unsigned width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/adder_level.sv
// adder_level: one 4-bit ripple slice with carry in/out.
module adder_level
    import alu_pkg::*;
(
    input  logic [NIBBLE_W-1:0] op1,
    input  logic [NIBBLE_W-1:0] op2,
    input  logic                c_in,
    output logic [NIBBLE_W-1:0] result,
    output logic                c_out
);

    // Nibble sum with carry; the extra bit becomes the carry out.
    always_comb begin
        {c_out, result} = {1'b0, op1} + {1'b0, op2} + {{NIBBLE_W{1'b0}}, c_in};
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add performed one nibble per cycle, LSB first,
// through a single reused adder_level slice with a registered carry.
// Optional subtract support (sub port, B inverted, carry forced to 1) under NSA_SUB_EN.
module nibble_serial_adder
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             c_in,
`ifdef NSA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow
);

    localparam int unsigned NN    = nibble_count(WIDTH);
    localparam int unsigned IDX_W = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);

    nsa_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0]    b_eff;
    logic                cin_eff;
    logic [NIBBLE_W-1:0] slice_res;
    logic                slice_cout;

    // Effective B operand and carry-in offered at accept time.
    always_comb begin
`ifdef NSA_SUB_EN
        b_eff   = sub ? ~op2 : op2;
        cin_eff = sub ? 1'b1 : c_in;
`else
        b_eff   = op2;
        cin_eff = c_in;
`endif
    end

    adder_level u_slice (
        .op1    (a_q[idx_q*NIBBLE_W +: NIBBLE_W]),
        .op2    (b_q[idx_q*NIBBLE_W +: NIBBLE_W]),
        .c_in   (carry_q),
        .result (slice_res),
        .c_out  (slice_cout)
    );

    // State register and datapath registers; reset restores all reset values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state and datapath update: capture in IDLE, one nibble per RUN edge, hold in DONE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op1;
                    b_d     = b_eff;
                    carry_d = cin_eff;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[idx_q*NIBBLE_W +: NIBBLE_W] = slice_res;
                carry_d = slice_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                    cout_d  = slice_cout;
                    // The final slice supplies the result MSB, so overflow uses it directly.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (slice_res[NIBBLE_W-1] != a_q[WIDTH-1]);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign c_out     = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed and random checks of nibble_serial_adder
// against a whole-word arithmetic reference model. Subtract cases need NSA_SUB_EN.
module tb_nibble_serial_adder;

    localparam int unsigned W  = 16;
    localparam int unsigned NN = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         c_out;
    logic         overflow;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .c_in      (c_in),
`ifdef NSA_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .c_out     (c_out),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {overflow, carry, sum} of A + B_eff + carry_eff as plain integers.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci, input logic s);
        logic [W-1:0] be;
        logic [W:0]   full;
        logic         ov;
        be   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (s ? 1'b1 : ci)};
        ov   = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
        return {ov, full[W], full[W-1:0]};
    endfunction

    // Offer operands; returns after the accept edge (+1).
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, input logic s);
        @(negedge clk);
        op1 = a; op2 = b; c_in = ci; sub = s; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid and check latency and results.
    task automatic finish_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic ci, input logic s);
        int unsigned cycles;
        logic [W+1:0] m;
        cycles = 0;
        while (!out_valid && cycles < 50) begin
            @(posedge clk);
            #1 cycles++;
        end
        m = model(a, b, ci, s);
        check({tag, " latency"}, cycles, NN);
        check({tag, " result"}, 32'(result), 32'(m[W-1:0]));
        check({tag, " c_out"}, 32'(c_out), 32'(m[W]));
        check({tag, " overflow"}, 32'(overflow), 32'(m[W+1]));
        check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
    endtask

    task automatic release_op(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic full_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ci, input logic s);
        start_op(a, b, ci, s);
        finish_op(tag, a, b, ci, s);
        release_op(tag);
    endtask

    initial begin
        logic [W-1:0] held;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rs;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op1 = '0; op2 = '0; c_in = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst result", 32'(result), 32'd0);
        check("rst c_out", 32'(c_out), 32'd0);
        check("rst overflow", 32'(overflow), 32'd0);

        // Carry chain, with an absolute expected value as well as the model.
        full_op("chain", 16'h0FFF, 16'h0001, 1'b0, 1'b0);
        start_op(16'h0FFF, 16'h0001, 1'b0, 1'b0);
        finish_op("chain2", 16'h0FFF, 16'h0001, 1'b0, 1'b0);
        check("chain const", 32'(result), 32'h1000);
        release_op("chain2");

        full_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        full_op("posovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        full_op("cin", 16'h1234, 16'h0000, 1'b1, 1'b0);
        full_op("negovf", 16'h8000, 16'h8000, 1'b0, 1'b0);

        // Backpressure: hold DONE with a competing in_valid that must be ignored.
        start_op(16'h00F0, 16'h0F0F, 1'b0, 1'b0);
        finish_op("bp", 16'h00F0, 16'h0F0F, 1'b0, 1'b0);
        held = result;
        op1 = 16'hAAAA; op2 = 16'h5555; c_in = 1'b1; in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp hold result", 32'(result), 32'(held));
            check("bp hold valid", 32'(out_valid), 32'd1);
            check("bp hold in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        release_op("bp");
        check("bp result kept", 32'(result), 32'(held));
        repeat (NN + 2) @(posedge clk);
        #1 check("bp no phantom op", 32'(out_valid), 32'd0);

        // Reset on the 2nd RUN edge.
        start_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("mid rst in_ready", 32'(in_ready), 32'd1);
        check("mid rst out_valid", 32'(out_valid), 32'd0);
        check("mid rst result", 32'(result), 32'd0);
        check("mid rst c_out", 32'(c_out), 32'd0);
        check("mid rst overflow", 32'(overflow), 32'd0);
        full_op("after rst", 16'h0001, 16'h0002, 1'b0, 1'b0);

`ifdef NSA_SUB_EN
        full_op("sub neg", 16'h0005, 16'h0007, 1'b0, 1'b1);
        full_op("sub ovf", 16'h8000, 16'h0001, 1'b0, 1'b1);
`endif

        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
`ifdef NSA_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            full_op("random", ra, rb, rc, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder built from one reused 4-bit `adder_level` slice. It consumes one nibble per cycle, LSB first, and carries between slices in a register. It sits directly downstream of the operand source and directly upstream of the ALU result mux. It trades latency for area against a fully unrolled ripple of adder levels.

## Interface
Parameters:
- `WIDTH`, default 16: operand/result width; must be a multiple of 4 and at least 4.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  operand offer.
- `in_ready`  out  1  high only in IDLE.
- `op1`  in  WIDTH  operand A (signed, two's complement).
- `op2`  in  WIDTH  operand B.
- `c_in`  in  1  carry into nibble 0.
- `sub`  in  1  subtract request; present only with `NSA_SUB_EN`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  WIDTH  sum.
- `c_out`  out  1  carry out of the MSB nibble.
- `overflow`  out  1  signed overflow.

## Operation
- FSM states:
  - IDLE:
    - `in_ready`=1.
    - On `in_valid`, capture `op1`, `op2` and the effective carry. Clear the nibble index and go to RUN.
  - RUN:
    - The slice adds nibble[idx] of A and B_eff with the carry register, all combinationally.
    - On each edge: write the slice result into result[idx], load carry with the slice `c_out`, and increment idx.
    - When idx = WIDTH/4-1, go to DONE on that edge. `c_out` is taken from the final slice carry.
  - DONE:
    - `out_valid`=1; `result`, `c_out` and `overflow` are held stable.
    - On `out_ready`, go to IDLE.
- B_eff = op2, or ~op2 when subtracting. Effective carry = `c_in`, or 1 when subtracting (`c_in` is ignored).
- `overflow` = (A[MSB] == B_eff[MSB]) && (result[MSB] != A[MSB]). It is computed when entering DONE.
- Arithmetic is modulo 2^WIDTH. The carry register is 1 bit; there is no saturation.
- `result` holds its last value after leaving DONE. It is only meaningful while `out_valid`=1.
- `in_valid` in RUN or DONE is ignored; operands are not sampled.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `c_out`=0, `overflow`=0, idx=0, carry=0.
- `in_ready` and `out_valid` are decoded from registered state, with no combinational path from inputs.
- Accept handshake at edge T:
  - RUN covers edges T+1..T+WIDTH/4.
  - `out_valid` is high after edge T+WIDTH/4 (4 cycles for WIDTH=16).
- Output handshake at edge U: `out_valid`=0 and `in_ready`=1 after U.
  - The next accept is possible at edge U+1.
  - Minimum spacing between accepts is WIDTH/4+2 cycles.
- `out_ready` low in DONE: hold indefinitely, with no output change.
- `rst` at any edge, including mid-RUN or in DONE, aborts the operation and restores the reset values on that edge. `rst` has priority over any handshake on the same edge.

## Configuration
- `NSA_SUB_EN` defined:
  - The `sub` port exists.
  - `sub` is sampled with the operands in IDLE and applies for the whole operation.
- `NSA_SUB_EN` undefined:
  - No `sub` port.
  - B_eff = op2 and effective carry = `c_in`, always.

## Structure
- Shared package `alu_pkg`:
  - `NIBBLE_W`=4.
  - Default `WORD_W`=16.
  - The state enum `nsa_state_t` {IDLE, RUN, DONE}.
  - A function giving the nibble count for a width.
- One sub-module: the existing `adder_level` (4-bit slice; `op1`, `op2`, `c_in`, `result`, `c_out`), instantiated once.
  - Nibbles are selected with an indexed part-select on idx.

## Test plan
- Carry chain: 0x0FFF + 0x0001, `c_in`=0 -> `result`=0x1000, `c_out`=0, `overflow`=0; `out_valid` 4 cycles after accept.
- Wrap: 0xFFFF + 0x0001 -> 0x0000, `c_out`=1, `overflow`=0. Then 0x7FFF + 0x0001 -> 0x8000, `c_out`=0, `overflow`=1.
- Carry in: 0x1234 + 0x0000, `c_in`=1 -> 0x1235. Also 0x8000 + 0x8000 -> 0x0000, `c_out`=1, `overflow`=1.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles in DONE -> outputs stable and `in_ready`=0.
  - A new `in_valid` in DONE is ignored.
  - Release -> IDLE on the next cycle.
- Reset mid-op: assert `rst` on the 2nd RUN edge -> all outputs reach reset values on that edge. A subsequent 0x0001 + 0x0002 then gives 0x0003.
- With `NSA_SUB_EN`: 0x0005 - 0x0007, `sub`=1, `c_in`=0 -> 0xFFFE, `c_out`=0, `overflow`=0. Also 0x8000 - 0x0001 -> 0x7FFF, `c_out`=1, `overflow`=1.
